alu_mb_seq: RTL

- Multi-byte add/subtract sequencer that time-shares the 8-bit ripple ALU.
- Latches two NBYTES*8-bit operands on a start handshake, feeds them through the ALU one byte per cycle (LSB first), and chains the carry between bytes.
- Assembles the wide result plus carry, zero and signed-overflow flags.
- Sits between the processor control unit and the ALU instance; the ALU stays purely combinational, and this block owns its a/b/cin/sel inputs.

---
 rtl/alu_mb_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mb_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mb_seq
// Description : Multi-byte add/subtract sequencer. Latches two NBYTES*8-bit
//               operands on an accepted start, walks them through an external
//               combinational 8-bit ALU one byte per cycle (LSB first),
//               chains the carry between bytes, and assembles the wide result
//               together with carry, zero and signed-overflow flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   1           system clock, rising edge
//   rst       in   1           synchronous reset, active low
//   start     in   1           request pulse, accepted only while busy=0
//   op_a      in   NBYTES*8    operand A
//   op_b      in   NBYTES*8    operand B
//   op_sel    in   1           0 = add, 1 = subtract (a + ~b + cin)
//   op_cin    in   1           carry into byte 0 (1 for plain subtract)
//   alu_a     out  8           byte of A presented to the ALU
//   alu_b     out  8           byte of B presented to the ALU
//   alu_cin   out  1           carry into the ALU
//   alu_sel   out  1           ALU add/sub select
//   alu_y     in   8           ALU sum byte
//   alu_cout  in   1           ALU carry out
//   busy      out  1           operation in progress (RUN or DONE)
//   done      out  1           one-cycle pulse, result and flags valid
//   result    out  NBYTES*8    assembled result
//   cout      out  1           final carry (subtract: 1 = no borrow)
//   zero      out  1           result == 0
//   ovf       out  1           two's-complement overflow of full width
// ============================================================================
module alu_mb_seq #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NBYTES*8-1:0]   op_a,
    input  logic [NBYTES*8-1:0]   op_b,
    input  logic                  op_sel,
    input  logic                  op_cin,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_cin,
    output logic                  alu_sel,
    input  logic [7:0]            alu_y,
    input  logic                  alu_cout,
    output logic                  busy,
    output logic                  done,
    output logic [NBYTES*8-1:0]   result,
    output logic                  cout,
    output logic                  zero,
    output logic                  ovf
);

    localparam int c_width   = NBYTES * 8;
    // Keep the index at least one bit wide so NBYTES=1 still elaborates.
    localparam int c_idx_w   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NBYTES - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]          r_state;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_width-1:0]  r_a;
    logic [c_width-1:0]  r_b;
    logic                r_sel;
    logic                r_carry;
    logic [c_width-1:0]  r_result;
    logic                r_cout;
    logic                r_zero;
    logic                r_ovf;

    logic [7:0]          w_a_byte [NBYTES];
    logic [7:0]          w_b_byte [NBYTES];
    logic [7:0]          w_alu_a;
    logic [7:0]          w_alu_b;
    logic [c_width-1:0]  w_next_result;
    logic                w_a7;
    logic                w_beff7;
    logic                w_ovf;

    // Split the latched operands into byte lanes for the per-cycle mux.
    genvar g;
    generate
        for (g = 0; g < NBYTES; g++) begin : g_byte_lane
            assign w_a_byte[g] = r_a[8*g +: 8];
            assign w_b_byte[g] = r_b[8*g +: 8];
        end
    endgenerate

    // Byte select driven by the running index. Outside RUN the index rests
    // at 0, so the ALU sees byte 0 of whatever operands were last latched.
    always_comb begin
        w_alu_a = 8'h00;
        w_alu_b = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_alu_a = w_a_byte[k];
                w_alu_b = w_b_byte[k];
            end
        end
    end

    // Result with the current ALU byte merged in; used both for the register
    // update and for the zero flag on the final byte, so that flag sees the
    // complete value in the same edge the last byte lands.
    always_comb begin
        w_next_result = r_result;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_next_result[8*k +: 8] = alu_y;
            end
        end
    end

    // Signed overflow: both effective operands share a sign and the sum sign
    // differs. The effective B sign is inverted for subtract because the ALU
    // adds ~b.
    assign w_a7    = r_a[c_width-1];
    assign w_beff7 = r_b[c_width-1] ^ r_sel;
    assign w_ovf   = (w_a7 == w_beff7) && (alu_y[7] != w_a7);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_st_idle;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_sel    <= op_sel;
                        r_carry  <= op_cin;
                        r_idx    <= '0;
                        // Previous result/flags are discarded on acceptance.
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_zero   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= c_st_run;
                    end
                end

                c_st_run: begin
                    r_result <= w_next_result;
                    r_carry  <= alu_cout;
                    if (r_idx == c_last_idx) begin
                        r_cout  <= alu_cout;
                        r_zero  <= ~|w_next_result;
                        r_ovf   <= w_ovf;
                        r_idx   <= '0;
                        r_state <= c_st_done;
                    end else begin
                        r_idx   <= r_idx + c_idx_w'(1);
                    end
                end

                c_st_done: begin
                    // Single-cycle done; start is not looked at here.
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign alu_a   = w_alu_a;
    assign alu_b   = w_alu_b;
    assign alu_cin = r_carry;
    assign alu_sel = r_sel;

    assign busy    = (r_state != c_st_idle);
    assign done    = (r_state == c_st_done);
    assign result  = r_result;
    assign cout    = r_cout;
    assign zero    = r_zero;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire
